multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Main state machine of the multi-cycle RV32I core. Sits directly upstream of the ALU control decoder and the ALU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives aluop and the datapath mux and strobe controls, and consumes alu_bcond to resolve branches.
- One instruction is in flight at a time; there is no overlap between instructions.

Parameters:
- MEM_HANDSHAKE, default 1: 1 = memory states hold until mem_ready is high; 0 = mem_ready is ignored and every memory access takes one cycle.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instruction register bits [6:0]
- funct3  in  3  instruction register bits [14:12]
- alu_bcond  in  3  from ALU: [0] result==0, [1] result<0, [2] result>0
- ecall_halt_req  in  1  register x17==10, evaluated in ID
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  load PC
- pc_source  out  1  0 = ALU result, 1 = ALUOut register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  load instruction register
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B register, 01 = constant 4, 10 = immediate
- aluop  out  2  00 = add, 01 = sub, 10 = R-type, 11 = I-type
- reg_write  out  1  register file write enable
- wb_sel  out  2  00 = ALUOut, 01 = MDR, 10 = PC+4
- is_halted  out  1  sticky halt flag

Behaviour:
- Outputs are Moore-decoded from state; the only exception is pc_write in EX_BR (see below).
- Any output not listed for a state is 0.
- On reset, state goes to IF and all outputs are 0.
- Reset takes priority in every state, including mid-access and HALT.
- IF: i_or_d=0, mem_read=1, ir_write=mem_ready. Move to ID on mem_ready, otherwise stay.
- ID: alu_src_a=0, alu_src_b=10, aluop=00 (branch/JAL target computed into ALUOut). Next state by opcode:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 and 0100011 -> EX_ADDR
  - 1100011 -> EX_BR
  - 1101111 -> EX_JAL
  - 1100111 -> EX_JALR
  - 1110011 -> HALT if ecall_halt_req, else PC_INC
  - any other opcode -> PC_INC (treated as NOP)
- EX_R: alu_src_a=1, alu_src_b=00, aluop=10. Next: WB.
- EX_I: alu_src_a=1, alu_src_b=10, aluop=11. Next: WB.
- EX_ADDR: alu_src_a=1, alu_src_b=10, aluop=00. Next: MEM_RD for a load, MEM_WR for a store.
- MEM_RD: i_or_d=1, mem_read=1. Move to WB_LD on mem_ready.
- MEM_WR: i_or_d=1, mem_write=1. Move to PC_INC on mem_ready.
- mem_read and mem_write are held steady for every cycle that mem_ready is low.
- WB: reg_write=1, wb_sel=00. Next: PC_INC.
- WB_LD: reg_write=1, wb_sel=01. Next: PC_INC.
- EX_BR: alu_src_a=1, alu_src_b=00, aluop=01, pc_source=1.
  - taken = funct3 000: bcond[0]; 001: !bcond[0]; 100: bcond[1]; 101: !bcond[1]; any other funct3: 0.
  - pc_write=taken (combinational). Next: IF if taken, else PC_INC.
- EX_JAL: reg_write=1, wb_sel=10, pc_write=1, pc_source=1. Next: IF.
- EX_JALR: alu_src_a=1, alu_src_b=10, aluop=00, reg_write=1, wb_sel=10, pc_write=1, pc_source=0. Next: IF. The datapath clears the LSB of the new PC.
- PC_INC: alu_src_a=0, alu_src_b=01, aluop=00, pc_write=1, pc_source=0. Next: IF.
- HALT: is_halted=1 and all strobes 0. Absorbing; only reset leaves it.
- When MEM_HANDSHAKE=0, mem_ready is treated as constant 1.
- Cycle counts with mem_ready tied high:
  - R/I-type: 5 cycles
  - load: 6 cycles
  - store: 5 cycles
  - taken branch, JAL, JALR: 3 cycles
  - not-taken branch: 4 cycles

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, adds two 32-bit outputs:
  - cycle_count: increments every cycle while not halted.
  - instret: increments on every transition into IF, excluding the one coming out of reset.
- Both counters reset to 0, wrap modulo 2^32, and freeze in HALT.
- When not defined, neither port nor any counter logic exists.

Decomposition:
- Shared package/header ctrl_defs holds:
  - the state encoding (4 bits, 14 states)
  - opcode constants
  - aluop, alu_src_b, wb_sel and pc_source encodings
  - branch funct3 constants
- One combinational sub-module: branch_resolve (funct3, alu_bcond -> taken).

Test Plan:
- add (opcode 0110011), mem_ready=1 -> states IF, ID, EX_R, WB, PC_INC; reg_write only in WB; aluop=10 only in EX_R.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read and i_or_d=1 held for 4 cycles; WB_LD with wb_sel=01 follows.
- beq, funct3=000, alu_bcond=001 -> pc_write=1, pc_source=1 in EX_BR, then IF. Same with alu_bcond=100 -> PC_INC path.
- ecall with ecall_halt_req=1 -> HALT after ID; is_halted=1; no strobes for 20 cycles; reset -> IF, is_halted=0.
- jalr -> EX_JALR has reg_write=1, wb_sel=10, pc_write=1, pc_source=0 in the same cycle.
- reset asserted during MEM_WR with mem_ready low -> next cycle state is IF and mem_write=0. With CTRL_PERF_CNT_EN, cycle_count=0 and instret=0.

Source files
------------

// File: rtl/ctrl_defs_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: states, opcodes, mux selects and the
// per-state Moore decode of the datapath controls.
package ctrl_defs_pkg;

   typedef enum logic [3:0] {
      StIf     = 4'd0,
      StId     = 4'd1,
      StExR    = 4'd2,
      StExI    = 4'd3,
      StExAddr = 4'd4,
      StMemRd  = 4'd5,
      StMemWr  = 4'd6,
      StWb     = 4'd7,
      StWbLd   = 4'd8,
      StExBr   = 4'd9,
      StExJal  = 4'd10,
      StExJalr = 4'd11,
      StPcInc  = 4'd12,
      StHalt   = 4'd13
   } state_e;

   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpIType  = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpSystem = 7'b1110011;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpRType = 2'b10;
   localparam logic [1:0] AluOpIType = 2'b11;

   localparam logic [1:0] SrcBReg  = 2'b00;
   localparam logic [1:0] SrcBFour = 2'b01;
   localparam logic [1:0] SrcBImm  = 2'b10;

   localparam logic [1:0] WbAluOut  = 2'b00;
   localparam logic [1:0] WbMdr     = 2'b01;
   localparam logic [1:0] WbPcPlus4 = 2'b10;

   localparam logic PcSrcAlu    = 1'b0;
   localparam logic PcSrcAluOut = 1'b1;

   localparam logic [2:0] F3Beq = 3'b000;
   localparam logic [2:0] F3Bne = 3'b001;
   localparam logic [2:0] F3Blt = 3'b100;
   localparam logic [2:0] F3Bge = 3'b101;

   typedef struct packed {
      logic       pc_write;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       is_halted;
   } ctrl_t;

   // ir_write and the branch pc_write depend on inputs and are overlaid by the top.
   function automatic ctrl_t decode_state(input state_e st);
      ctrl_t c;
      c = '0;
      case (st)
         StIf: begin
            c.mem_read = 1'b1;
         end
         StId: begin
            c.alu_src_b = SrcBImm;
            c.aluop     = AluOpAdd;
         end
         StExR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBReg;
            c.aluop     = AluOpRType;
         end
         StExI: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBImm;
            c.aluop     = AluOpIType;
         end
         StExAddr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBImm;
            c.aluop     = AluOpAdd;
         end
         StMemRd: begin
            c.i_or_d   = 1'b1;
            c.mem_read = 1'b1;
         end
         StMemWr: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
         end
         StWb: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WbAluOut;
         end
         StWbLd: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WbMdr;
         end
         StExBr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBReg;
            c.aluop     = AluOpSub;
            c.pc_source = PcSrcAluOut;
         end
         StExJal: begin
            c.reg_write = 1'b1;
            c.wb_sel    = WbPcPlus4;
            c.pc_write  = 1'b1;
            c.pc_source = PcSrcAluOut;
         end
         StExJalr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SrcBImm;
            c.aluop     = AluOpAdd;
            c.reg_write = 1'b1;
            c.wb_sel    = WbPcPlus4;
            c.pc_write  = 1'b1;
            c.pc_source = PcSrcAlu;
         end
         StPcInc: begin
            c.alu_src_b = SrcBFour;
            c.aluop     = AluOpAdd;
            c.pc_write  = 1'b1;
            c.pc_source = PcSrcAlu;
         end
         StHalt: begin
            c.is_halted = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from funct3 and the ALU compare flags of the subtraction.
module branch_resolve
   import ctrl_defs_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [2:0] alu_bcond,
   output logic       taken
);

   logic unused_gt;
   assign unused_gt = alu_bcond[2];

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3Beq:   taken = alu_bcond[0];
         F3Bne:   taken = ~alu_bcond[0];
         F3Blt:   taken = alu_bcond[1];
         F3Bge:   taken = ~alu_bcond[1];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencer of the multi-cycle RV32I core (IF/ID/EX/MEM/WB, one instruction in flight).
// Define CTRL_PERF_CNT_EN to add the cycle_count and instret performance counters.
module multicycle_ctrl_fsm
   import ctrl_defs_pkg::*;
#(
   parameter int unsigned MEM_HANDSHAKE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [2:0]  alu_bcond,
   input  logic        ecall_halt_req,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_source,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  aluop,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        is_halted
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instret
`endif
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q, ctrl_o;
   logic   rdy, taken;

   assign rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

   branch_resolve u_branch_resolve (
      .funct3    (funct3),
      .alu_bcond (alu_bcond),
      .taken     (taken)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIf: if (rdy) state_d = StId;
         StId: begin
            case (opcode)
               OpRType:         state_d = StExR;
               OpIType:         state_d = StExI;
               OpLoad, OpStore: state_d = StExAddr;
               OpBranch:        state_d = StExBr;
               OpJal:           state_d = StExJal;
               OpJalr:          state_d = StExJalr;
               OpSystem:        state_d = ecall_halt_req ? StHalt : StPcInc;
               default:         state_d = StPcInc;
            endcase
         end
         StExR, StExI: state_d = StWb;
         StExAddr:     state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
         StMemRd:      if (rdy) state_d = StWbLd;
         StMemWr:      if (rdy) state_d = StPcInc;
         StWb, StWbLd: state_d = StPcInc;
         StExBr:       state_d = taken ? StIf : StPcInc;
         StExJal, StExJalr, StPcInc: state_d = StIf;
         StHalt:       state_d = StHalt;
         default:      state_d = StIf;
      endcase
   end

   // Moore controls are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIf;
         ctrl_q  <= decode_state(StIf);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode_state(state_d);
      end
   end

   always_comb begin
      ctrl_o          = ctrl_q;
      ctrl_o.ir_write = (state_q == StIf) && rdy;
      if (state_q == StExBr) ctrl_o.pc_write = taken;
      if (reset) ctrl_o = '0;
   end

   assign pc_write  = ctrl_o.pc_write;
   assign pc_source = ctrl_o.pc_source;
   assign i_or_d    = ctrl_o.i_or_d;
   assign mem_read  = ctrl_o.mem_read;
   assign mem_write = ctrl_o.mem_write;
   assign ir_write  = ctrl_o.ir_write;
   assign alu_src_a = ctrl_o.alu_src_a;
   assign alu_src_b = ctrl_o.alu_src_b;
   assign aluop     = ctrl_o.aluop;
   assign reg_write = ctrl_o.reg_write;
   assign wb_sel    = ctrl_o.wb_sel;
   assign is_halted = ctrl_o.is_halted;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_count_q, cycle_count_d;
   logic [31:0] instret_q, instret_d;

   always_comb begin
      cycle_count_d = cycle_count_q;
      instret_d     = instret_q;
      if (state_q != StHalt) cycle_count_d = cycle_count_q + 32'd1;
      if ((state_d == StIf) && (state_q != StIf)) instret_d = instret_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count_q <= '0;
         instret_q     <= '0;
      end else begin
         cycle_count_q <= cycle_count_d;
         instret_q     <= instret_d;
      end
   end

   assign cycle_count = cycle_count_q;
   assign instret     = instret_q;
`endif

endmodule
